// File: rtl/fp_addsub_if.sv
// Operand/result bundle for the pipelined floating-point adder/subtractor.
// master drives operands and controls, slave is the arithmetic pipeline.
interface fp_addsub_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_sub;
  logic         i_vld;
  logic         i_hold;
  logic [W-1:0] o_res;
  logic         o_res_vld;
  logic         o_ovf;
  logic         o_unf;
  logic         o_inx;
  logic         o_inv;

  modport master (
    output i_a, i_b, i_sub, i_vld, i_hold,
    input  o_res, o_res_vld, o_ovf, o_unf, o_inx, o_inv
  );

  modport slave (
    input  i_a, i_b, i_sub, i_vld, i_hold,
    output o_res, o_res_vld, o_ovf, o_unf, o_inx, o_inv
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754-style add/sub: operand capture, align, add, normalise/round.
// Round-to-nearest-even, gradual underflow, whole-pipeline hold.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic        clk,
  input logic        rst,
  fp_addsub_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int NW = MAN_W + 3;
  localparam int SW = MAN_W + 5;
  localparam int XW = EXP_W + 1;
  localparam int LW = $clog2(SW);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [31:0]      NW32    = NW;

  function automatic logic [LW-1:0] lzc(input logic [SW-2:0] v);
    lzc = LW'(SW - 1);
    for (int i = 0; i < SW - 1; i++)
      if (v[i]) lzc = LW'(SW - 2 - i);
  endfunction

  // n = {hidden, frac, G, R}; result carries one extra bit for mantissa rollover
  function automatic logic [MAN_W+1:0] rne_round(input logic [NW-1:0] n, input logic s);
    logic up;
    up = n[1] & (n[0] | s | n[2]);
    return {1'b0, n[NW-1:2]} + (MAN_W + 2)'(up);
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic [W-1:0] a_p0, b_p0;
  logic sub_p0;

  // operand capture
  always_ff @(posedge clk) begin
    if (!bus.i_hold) begin
      a_p0   <= bus.i_a;
      b_p0   <= bus.i_b;
      sub_p0 <= bus.i_sub;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!bus.i_hold) begin
      vld_p0 <= bus.i_vld;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S1: unpack, pick larger magnitude, align smaller with sticky
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb, xa, xb, ediff;
  logic [MAN_W-1:0] fa, fb;
  logic [NW-1:0] siga, sigb, sml_sig;
  logic [2*NW-1:0] wide;
  logic [31:0] sh_r;

  always_comb begin
    sa      = a_p0[W-1];
    sb      = b_p0[W-1] ^ sub_p0;
    ea      = a_p0[W-2:MAN_W];
    eb      = b_p0[W-2:MAN_W];
    fa      = a_p0[MAN_W-1:0];
    fb      = b_p0[MAN_W-1:0];
    a_nan   = (ea == EXP_MAX) && (fa != '0);
    b_nan   = (eb == EXP_MAX) && (fb != '0);
    a_inf   = (ea == EXP_MAX) && (fa == '0);
    b_inf   = (eb == EXP_MAX) && (fb == '0);
    xa      = (ea == '0) ? EXP_W'(1) : ea;
    xb      = (eb == '0) ? EXP_W'(1) : eb;
    siga    = {ea != '0, fa, 2'b00};
    sigb    = {eb != '0, fb, 2'b00};
    swap    = b_p0[W-2:0] > a_p0[W-2:0];
    ediff   = swap ? (xb - xa) : (xa - xb);
    sml_sig = swap ? siga : sigb;
    sh_r    = (32'(ediff) >= NW32) ? NW32 : 32'(ediff);
    wide    = {sml_sig, {NW{1'b0}}} >> sh_r;
  end

  logic sign_p1, same_p1, stk_p1, inv_p1, inf_p1, inf_sign_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [NW-1:0] big_p1, sml_p1;

  always_ff @(posedge clk) begin
    if (!bus.i_hold) begin
      sign_p1     <= swap ? sb : sa;
      same_p1     <= (sa == sb);
      exp_p1      <= swap ? xb : xa;
      big_p1      <= swap ? sigb : siga;
      sml_p1      <= wide[2*NW-1:NW];
      stk_p1      <= |wide[NW-1:0];
      inv_p1      <= a_nan | b_nan | (a_inf & b_inf & (sa != sb));
      inf_p1      <= a_inf | b_inf;
      inf_sign_p1 <= a_inf ? sa : sb;
    end
  end

  // S2: magnitude add/subtract; sticky rides as the LSB so borrows stay exact enough for RNE
  logic sign_p2, same_p2, inv_p2, inf_p2, inf_sign_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [SW-1:0] sum_p2;

  always_ff @(posedge clk) begin
    if (!bus.i_hold) begin
      sum_p2      <= same_p1 ? ({1'b0, big_p1, 1'b0} + {1'b0, sml_p1, stk_p1})
                             : ({1'b0, big_p1, 1'b0} - {1'b0, sml_p1, stk_p1});
      sign_p2     <= sign_p1;
      same_p2     <= same_p1;
      exp_p2      <= exp_p1;
      inv_p2      <= inv_p1;
      inf_p2      <= inf_p1;
      inf_sign_p2 <= inf_sign_p1;
    end
  end

  // S3: normalise (left shift stops at exponent 1), round, special-case select
  logic carry, zero_sum, grs;
  logic [LW-1:0] lz;
  logic [31:0] lim, shl;
  logic [SW-2:0] shifted;
  logic [NW-1:0] nrm;
  logic stk_n;
  logic [XW-1:0] exp_x, exp_n, exp_f;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac_f;
  logic [W-1:0] res_c;
  logic ovf_c, unf_c, inx_c, inv_c;

  always_comb begin
    exp_x    = {1'b0, exp_p2};
    carry    = sum_p2[SW-1];
    zero_sum = (sum_p2 == '0);
    lz       = lzc(sum_p2[SW-2:0]);
    lim      = 32'(exp_x) - 32'd1;
    shl      = (32'(lz) > lim) ? lim : 32'(lz);
    shifted  = sum_p2[SW-2:0] << shl;
    if (carry) begin
      nrm   = sum_p2[SW-1:2];
      stk_n = |sum_p2[1:0];
      exp_n = exp_x + XW'(1);
    end else begin
      nrm   = shifted[SW-2:1];
      stk_n = shifted[0];
      exp_n = exp_x - XW'(shl);
    end
    rnd = rne_round(nrm, stk_n);
    grs = |{nrm[1:0], stk_n};
    if (rnd[MAN_W+1]) begin
      exp_f  = exp_n + XW'(1);
      frac_f = '0;
    end else begin
      exp_f  = rnd[MAN_W] ? exp_n : '0;
      frac_f = rnd[MAN_W-1:0];
    end
    res_c = {sign_p2, exp_f[EXP_W-1:0], frac_f};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = grs;
    inv_c = 1'b0;
    if (inv_p2) begin
      res_c = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
      inx_c = 1'b0;
      inv_c = 1'b1;
    end else if (inf_p2) begin
      res_c = {inf_sign_p2, EXP_MAX, {MAN_W{1'b0}}};
      inx_c = 1'b0;
    end else if (zero_sum) begin
      res_c = {same_p2 & sign_p2, {(W-1){1'b0}}};
      inx_c = 1'b0;
    end else if (exp_f >= {1'b0, EXP_MAX}) begin
      res_c = {sign_p2, EXP_MAX, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else begin
      unf_c = (exp_f == '0) && (frac_f == '0);
    end
  end

  logic [W-1:0] res_p3;
  logic vld_p3, ovf_p3, unf_p3, inx_p3, inv_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p3 <= '0;
      vld_p3 <= 1'b0;
      ovf_p3 <= 1'b0;
      unf_p3 <= 1'b0;
      inx_p3 <= 1'b0;
      inv_p3 <= 1'b0;
    end else if (!bus.i_hold) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        res_p3 <= res_c;
        ovf_p3 <= ovf_c;
        unf_p3 <= unf_c;
        inx_p3 <= inx_c;
        inv_p3 <= inv_c;
      end
    end
  end

  assign bus.o_res     = res_p3;
  assign bus.o_res_vld = vld_p3;
  assign bus.o_ovf     = ovf_p3;
  assign bus.o_unf     = unf_p3;
  assign bus.o_inx     = inx_p3;
  assign bus.o_inv     = inv_p3;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe at half-precision widths.
module tb_fp_addsub_pipe;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  logic [15:0] st_a[8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                           16'h4500, 16'h4600, 16'hC000, 16'h3800};
  logic [15:0] st_b[8] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                           16'h3C00, 16'h4800, 16'hC000, 16'h3800};
  logic        st_s[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] st_r[8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4200,
                           16'h4600, 16'hC000, 16'hC400, 16'h3C00};

  fp_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus();

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.o_ovf, bus.o_unf, bus.o_inx, bus.o_inv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic vld);
    bus.i_a   = a;
    bus.i_b   = b;
    bus.i_sub = sub;
    bus.i_vld = vld;
  endtask

  // flags order: {ovf, unf, inx, inv}
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] res, input logic [3:0] flg);
    drive(a, b, sub, 1'b1);
    tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    check({tag, "_early"}, 32'(bus.o_res_vld), 32'd0);
    tick();
    check({tag, "_vld"}, 32'(bus.o_res_vld), 32'd1);
    check({tag, "_res"}, 32'(bus.o_res), 32'(res));
    check({tag, "_flags"}, 32'(flags()), 32'(flg));
    tick();
    check({tag, "_once"}, 32'(bus.o_res_vld), 32'd0);
  endtask

  task automatic drive_stream(input bit with_hold);
    for (int i = 0; i < 8; i++) begin
      if (with_hold && i == 4) begin
        drive(st_a[i], st_b[i], st_s[i], 1'b1);
        bus.i_hold = 1'b1;
        tick();
        tick();
        bus.i_hold = 1'b0;
      end
      drive(st_a[i], st_b[i], st_s[i], 1'b1);
      exp_q.push_back(st_r[i]);
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic collect(input string tag, input int span);
    int got_n = 0;
    int first = -1;
    int last = -1;
    logic [15:0] prev_res;
    logic prev_vld;
    logic h;
    logic [15:0] e;
    prev_res = bus.o_res;
    prev_vld = bus.o_res_vld;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      h = bus.i_hold;
      #2;
      if (h) begin
        check({tag, "_frz_res"}, 32'(bus.o_res), 32'(prev_res));
        check({tag, "_frz_vld"}, 32'(bus.o_res_vld), 32'(prev_vld));
      end else if (bus.o_res_vld) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_item"}, 32'(bus.o_res), 32'(e));
        got_n++;
        if (first < 0) first = c;
        last = c;
      end
      prev_res = bus.o_res;
      prev_vld = bus.o_res_vld;
    end
    check({tag, "_count"}, 32'(got_n), 32'd8);
    check({tag, "_span"}, 32'(last - first), 32'(span));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.i_hold = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    check("rst_res", 32'(bus.o_res), 32'd0);
    check("rst_vld", 32'(bus.o_res_vld), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    rst = 1'b0;
    tick();

    run_one("add_1p2",     16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
    run_one("cancel",      16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    run_one("negzero",     16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000);
    run_one("rne_tie",     16'h6800, 16'h3C00, 1'b0, 16'h6800, 4'b0010);
    run_one("rne_up",      16'h6800, 16'h4200, 1'b0, 16'h6802, 4'b0010);
    run_one("ovf_pos",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b1010);
    run_one("ovf_neg",     16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00, 4'b1010);
    run_one("inf_m_inf",   16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0001);
    run_one("inf_p_one",   16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000);
    run_one("nan_in",      16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0001);
    run_one("sub_sub",     16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    run_one("sub_to_norm", 16'h03FF, 16'h0001, 1'b0, 16'h0400, 4'b0000);
    run_one("norm_shift",  16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 4'b0000);
    run_one("neg_result",  16'h4000, 16'h4200, 1'b1, 16'hBC00, 4'b0000);

    fork
      drive_stream(1'b0);
      collect("stream", 7);
    join
    fork
      drive_stream(1'b1);
      collect("hold", 9);
    join

    for (int i = 0; i < 3; i++) begin
      drive(st_a[i], st_b[i], st_s[i], 1'b1);
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_res", 32'(bus.o_res), 32'd0);
    check("mid_rst_vld", 32'(bus.o_res_vld), 32'd0);
    check("mid_rst_flags", 32'(flags()), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", 32'(bus.o_res_vld), 32'd0);
    end
    run_one("post_rst_add", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
